serial_pattern_tx: RTL

//  Transmit side of the serial bit-stream link consumed by pattern_detector.

---
 rtl/serial_pattern_pkg.sv | 20 ++
 rtl/piso_shift_reg.sv | 37 +++
 rtl/serial_pattern_tx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/serial_pattern_pkg.sv
// rtl/serial_pattern_pkg.sv - shared state encoding and link defaults for the serial pattern link
package serial_pattern_pkg;

  // Transmitter states; also used by the detector bench to label link phases
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_PAR  = 2'd3
  } tx_state_e;

  localparam int         DEF_SYNC_W   = 4;
  localparam logic [3:0] DEF_SYNC_PAT = 4'b1101;
  localparam logic       DEF_IDLE_LVL = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out shift register, LSB first
module piso_shift_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              serial_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Load has priority over shift; vacated MSBs fill with zero
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = {1'b0, data_q[DATA_W-1:1]};
    end
  end

  // Register the word; reset clears any partially sent frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign serial_o = data_q[0];

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - sync pattern + LSB-first word serialiser; SERIAL_PATTERN_TX_PARITY_EN appends an even-parity bit
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT,
  parameter logic            IDLE_LVL = DEF_IDLE_LVL
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              O,
  output logic              O_VALID,
  output logic              FRAME_END,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(max_int(SYNC_W, DATA_W));
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_PENUL = CNT_W'(DATA_W - 2);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             o_q;
  logic             active_q;
  logic             frame_end_q;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic             par_q;
`endif

  logic accept;
  logic shift_en;
  logic sr_out;

  // Selects one sync-pattern bit by counter value without a variable part-select
  function automatic logic sync_bit(input logic [CNT_W-1:0] idx);
    logic b;
    b = SYNC_PAT[0];
    for (int i = 0; i < SYNC_W; i++) begin
      if (idx == CNT_W'(i)) b = SYNC_PAT[i];
    end
    return b;
  endfunction

  // A new word is taken when idle or during the last bit of the current frame
  assign DIN_READY = (state_q == ST_IDLE) | frame_end_q;
  assign accept    = DIN_VALID & DIN_READY;

  // The shifter advances on the edge that presents each data bit, so its bit0
  // always holds the next bit to send
  assign shift_en = ((state_q == ST_SYNC) && (cnt_q == SYNC_LAST)) ||
                    ((state_q == ST_DATA) && (cnt_q != DATA_LAST));

  piso_shift_reg #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk_i    (CLK),
    .rst_i    (RES),
    .load_i   (accept),
    .shift_i  (shift_en),
    .data_i   (DIN),
    .serial_o (sr_out)
  );

  // Frame sequencer with registered serial outputs
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      o_q         <= IDLE_LVL;
      active_q    <= 1'b0;
      frame_end_q <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else if ((state_q == ST_IDLE) || frame_end_q) begin
      cnt_q       <= '0;
      frame_end_q <= 1'b0;
      if (accept) begin
        state_q  <= ST_SYNC;
        o_q      <= SYNC_PAT[0];
        active_q <= 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        par_q    <= ^DIN;
`endif
      end else begin
        state_q  <= ST_IDLE;
        o_q      <= IDLE_LVL;
        active_q <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (cnt_q == SYNC_LAST) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            o_q     <= sr_out;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            o_q   <= sync_bit(cnt_q + CNT_W'(1));
          end
        end
        ST_DATA: begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          if (cnt_q == DATA_LAST) begin
            state_q     <= ST_PAR;
            cnt_q       <= '0;
            o_q         <= par_q;
            frame_end_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            o_q   <= sr_out;
          end
`else
          cnt_q       <= cnt_q + CNT_W'(1);
          o_q         <= sr_out;
          frame_end_q <= (cnt_q == DATA_PENUL);
`endif
        end
        default: begin
          state_q  <= ST_IDLE;
          cnt_q    <= '0;
          o_q      <= IDLE_LVL;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign O         = o_q;
  assign O_VALID   = active_q;
  assign BUSY      = active_q;
  assign FRAME_END = frame_end_q;

endmodule
